cpu_ctrl_fsm: RTL
=================

# cpu_ctrl_fsm

Multi-cycle control sequencer for the RISC CPU datapath. It runs instruction fetch through a memory handshake, then PC update and decode. It then drives the register-file, ALU, status and memory control strobes for MOV, MVN, ADD, AND, CMP, LDR, STR and HALT. It sits between the instruction register and the datapath/memory interface inside `cpu`, and it replaces the wait-for-`s` controller with a self-fetching one.

## Interface
- `MAX_WAIT`, 15: maximum consecutive cycles without `mem_rdy` in a memory wait state before a bus error.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  3  IR[15:13]
- `op`  in  2  IR[12:11]
- `mem_rdy`  in  1  memory completes current read/write this cycle
- `reset_pc`, `load_pc`, `load_ir`, `load_addr`, `addr_sel`  out  1 each  PC/IR/data-address controls (`addr_sel`=1 selects PC)
- `mem_cmd`  out  2  00 NONE, 01 READ, 10 WRITE
- `nsel`  out  3  one-hot: 001 Rn, 010 Rd, 100 Rm
- `vsel`  out  2  00 C, 10 sximm8, 11 mdata
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`  out  1 each  datapath strobes (`asel`=1 zeroes A, `bsel`=1 selects sximm5)
- `halted`  out  1  controller in HALT
- `bus_err`  out  1  sticky; set on memory timeout
- `state`  out  5  present state, debug/verification only

## Operation
- Moore machine; outputs are decoded from the state only. Any strobe not listed for a state is 0.
- RST: `reset_pc`=1, `load_pc`=1 → IF1.
- IF1: `addr_sel`=1, `mem_cmd`=01. Wait state; goes to IF2 on `mem_rdy`.
- IF2: `addr_sel`=1, `mem_cmd`=01, `load_ir`=1 → UPC.
- UPC: `load_pc`=1 → DEC. DEC drives no strobes and branches on {opcode, op}.
- 110/10 MOV imm: WIMM (`nsel`=Rn, `vsel`=10, `write`) → IF1.
- 110/00 MOV reg and 101/11 MVN: GETB → ALU → WBC.
- 101/00 ADD and 101/10 AND: GETA → GETB → ALU → WBC.
  - GETA: `nsel`=Rn, `loada`.
  - GETB: `nsel`=Rm, `loadb`.
  - ALU: `loadc`, with `asel`=1 for MOV/MVN only.
  - WBC: `nsel`=Rd, `vsel`=00, `write` → IF1.
- 101/01 CMP: GETA → GETB → CMPS (`loads`=1) → IF1. No write.
- 011/00 LDR: GETA → ADDR (`bsel`=1, `loadc`) → LDA (`load_addr`) → MRD → MWB → IF1.
  - MRD is a wait state: `addr_sel`=0, `mem_cmd`=01.
  - MWB: `mem_cmd`=01, `nsel`=Rd, `vsel`=11, `write`.
- 100/00 STR: GETA → ADDR → LDA → STB → STALU → MWR → IF1.
  - STB: `nsel`=Rd, `loadb`.
  - STALU: `asel`=1, `loadc`.
  - MWR is a wait state: `addr_sel`=0, `mem_cmd`=10.
- 111/xx HALT, and any undefined {opcode, op}: go to HALT. HALT holds `halted`=1 until reset.
- Wait counter, width clog2(MAX_WAIT+1):
  - Cleared on entry to IF1/MRD/MWR.
  - Increments on each edge in a wait state with `mem_rdy`=0.
  - At an edge with count==MAX_WAIT and `mem_rdy`=0: go to HALT and set `bus_err`.
  - `mem_rdy`=1 always wins over timeout.

## Timing
- Reset low: state=RST immediately, with no clock needed.
  - `reset_pc`=`load_pc`=1; all other outputs 0, including `bus_err`, `halted` and `mem_cmd`.
  - First edge after release goes to IF1.
- `mem_rdy` is sampled at the rising edge. The command and address are held unchanged for every stalled cycle.
- Cycles from IF1 to the next IF1, with zero-wait memory: MOV imm 5, MOV reg/MVN 7, ADD/AND 8, CMP 7, LDR 9, STR 10. Each stall cycle adds 1.
- Timeout: `mem_rdy` stuck low gives MAX_WAIT+1 cycles in the wait state, then HALT.
- Reset asserted mid-instruction aborts it: `mem_cmd` drops to 00 asynchronously, and no partial write is issued after release.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - 5-bit state encodings: RST, IF1, IF2, UPC, DEC, WIMM, GETA, GETB, ALU, WBC, CMPS, ADDR, LDA, MRD, MWB, STB, STALU, MWR, HALT.
  - Opcode/op constants.
  - `MEM_NONE`/`MEM_READ`/`MEM_WRITE`.
  - `NSEL_RN`/`RD`/`RM`.
  - `VSEL_C`/`IMM`/`MDATA`.
- One sub-module, `cpu_instr_dec`: combinational {opcode, op} → instruction class (MOVI, MOVR, MVN, ADD, AND, CMP, LDR, STR, HALT/illegal), used by DEC and by the ALU-state `asel`.

## Test plan
- Release reset, MOV imm (110/10), `mem_rdy`=1 → state sequence RST, IF1, IF2, UPC, DEC, WIMM, IF1; WIMM shows `write`=1, `nsel`=001, `vsel`=10.
- ADD (101/00), `mem_rdy`=1 → 8 cycles IF1 to IF1; `loada`+`nsel`=001, then `loadb`+`nsel`=100, then `loadc` with `asel`=0, then `write`+`nsel`=010+`vsel`=00.
- CMP (101/01) → `loads` high exactly 1 cycle and `write` never asserted; MVN (101/11) → ALU state has `asel`=1 and no GETA.
- LDR with `mem_rdy` low for 3 cycles in MRD → MRD lasts 4 cycles with `mem_cmd`=01 and `addr_sel`=0 throughout, then MWB has `vsel`=11 and `write`=1.
- `mem_rdy` stuck 0 in IF1, MAX_WAIT=15 → HALT after 16 cycles with `bus_err`=`halted`=1, held for 50 cycles; reset low clears both immediately.
- Reset asserted during MWR of STR → `mem_cmd` 00 in the same cycle without a clock edge; after release, IF1 with `mem_cmd`=01 follows RST.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: states,
// instruction fields, memory commands and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_IF1   = 5'd1,
    S_IF2   = 5'd2,
    S_UPC   = 5'd3,
    S_DEC   = 5'd4,
    S_WIMM  = 5'd5,
    S_GETA  = 5'd6,
    S_GETB  = 5'd7,
    S_ALU   = 5'd8,
    S_WBC   = 5'd9,
    S_CMPS  = 5'd10,
    S_ADDR  = 5'd11,
    S_LDA   = 5'd12,
    S_MRD   = 5'd13,
    S_MWB   = 5'd14,
    S_STB   = 5'd15,
    S_STALU = 5'd16,
    S_MWR   = 5'd17,
    S_HALT  = 5'd18
  } state_t;

  typedef enum logic [3:0] {
    I_MOVI = 4'd0,
    I_MOVR = 4'd1,
    I_MVN  = 4'd2,
    I_ADD  = 4'd3,
    I_AND  = 4'd4,
    I_CMP  = 4'd5,
    I_LDR  = 4'd6,
    I_STR  = 4'd7,
    I_HALT = 4'd8
  } iclass_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/cpu_instr_dec.sv
// Maps the instruction-register {opcode, op} fields onto an instruction class;
// anything not recognised is treated as HALT.
module cpu_instr_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output iclass_t    cls
);

  always_comb begin
    cls = I_HALT;
    if (opcode != OPC_HALT) begin
      case ({opcode, op})
        {OPC_MOV, OP_MOV_IMM}: cls = I_MOVI;
        {OPC_MOV, OP_MOV_REG}: cls = I_MOVR;
        {OPC_ALU, OP_MVN}:     cls = I_MVN;
        {OPC_ALU, OP_ADD}:     cls = I_ADD;
        {OPC_ALU, OP_AND}:     cls = I_AND;
        {OPC_ALU, OP_CMP}:     cls = I_CMP;
        {OPC_LDR, OP_MEM}:     cls = I_LDR;
        {OPC_STR, OP_MEM}:     cls = I_STR;
        default:               cls = I_HALT;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Self-fetching multi-cycle control sequencer: fetch via memory handshake,
// PC update, decode, then per-instruction datapath/memory strobes.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_rdy,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted,
  output logic       bus_err,
  output logic [4:0] state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t           st, st_nxt;
  iclass_t          cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout;

  cpu_instr_dec u_dec (
    .opcode (opcode),
    .op     (op),
    .cls    (cls)
  );

  assign in_wait = (st == S_IF1) || (st == S_MRD) || (st == S_MWR);
  // mem_rdy takes priority: a completing transfer on the last allowed cycle is not a timeout
  assign timeout = in_wait && !mem_rdy && (wait_cnt == CNT_W'(MAX_WAIT));
  assign state   = st;

  // Counter sits at zero outside wait states, so every wait-state entry starts from 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= S_RST;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      st <= st_nxt;
      if (in_wait && !mem_rdy && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                 wait_cnt <= '0;
      if (timeout) bus_err <= 1'b1;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_RST:   st_nxt = S_IF1;
      S_IF1:   if (mem_rdy) st_nxt = S_IF2; else if (timeout) st_nxt = S_HALT;
      S_IF2:   st_nxt = S_UPC;
      S_UPC:   st_nxt = S_DEC;
      S_DEC: begin
        case (cls)
          I_MOVI:                              st_nxt = S_WIMM;
          I_MOVR, I_MVN:                       st_nxt = S_GETB;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR:   st_nxt = S_GETA;
          default:                             st_nxt = S_HALT;
        endcase
      end
      S_WIMM:  st_nxt = S_IF1;
      S_GETA:  st_nxt = (cls == I_LDR || cls == I_STR) ? S_ADDR : S_GETB;
      S_GETB:  st_nxt = (cls == I_CMP) ? S_CMPS : S_ALU;
      S_ALU:   st_nxt = S_WBC;
      S_WBC:   st_nxt = S_IF1;
      S_CMPS:  st_nxt = S_IF1;
      S_ADDR:  st_nxt = S_LDA;
      S_LDA:   st_nxt = (cls == I_STR) ? S_STB : S_MRD;
      S_MRD:   if (mem_rdy) st_nxt = S_MWB; else if (timeout) st_nxt = S_HALT;
      S_MWB:   st_nxt = S_IF1;
      S_STB:   st_nxt = S_STALU;
      S_STALU: st_nxt = S_MWR;
      S_MWR:   if (mem_rdy) st_nxt = S_IF1; else if (timeout) st_nxt = S_HALT;
      S_HALT:  st_nxt = S_HALT;
      default: st_nxt = S_HALT;
    endcase
  end

  // Moore outputs: decoded from the present state (plus the stable IR class for asel)
  always_comb begin
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    nsel      = 3'b000;
    vsel      = VSEL_C;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (st)
      S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:   begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:   begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPC:   load_pc = 1'b1;
      S_WIMM:  begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
      S_GETA:  begin nsel = NSEL_RN; loada = 1'b1; end
      S_GETB:  begin nsel = NSEL_RM; loadb = 1'b1; end
      S_ALU:   begin loadc = 1'b1; asel = (cls == I_MOVR) || (cls == I_MVN); end
      S_WBC:   begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_CMPS:  loads = 1'b1;
      S_ADDR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LDA:   load_addr = 1'b1;
      S_MRD:   mem_cmd = MEM_READ;
      S_MWB:   begin mem_cmd = MEM_READ; nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; end
      S_STB:   begin nsel = NSEL_RD; loadb = 1'b1; end
      S_STALU: begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:   mem_cmd = MEM_WRITE;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
